// File: rtl/i2c_pkg.sv
// Shared I2C types and default timing constants.
// The defaults assume a 156.25 MHz system clock and 400 kHz SCL.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        WAIT_HI,
        HIGH
    } scl_state_e;

    localparam int LOW_CYCLES_DEF  = 250;
    localparam int HIGH_CYCLES_DEF = 138;
    localparam int STRETCH_MAX_DEF = 4096;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/i2c_scl_gen_if.sv
// Control, pin and strobe bundle between the SCL generator and the byte/bit engine.
// The pin readback scl_i enters the generator through this bundle.
interface i2c_scl_gen_if;

    logic en_i;
    logic hold_i;
    logic scl_i;
    logic scl_t;
    logic busy_o;
    logic fall_tick_o;
    logic data_tick_o;
    logic samp_tick_o;
    logic stretch_o;
    logic timeout_o;

    modport master (
        output en_i, hold_i, scl_i,
        input  scl_t, busy_o, fall_tick_o, data_tick_o, samp_tick_o, stretch_o, timeout_o
    );

    modport slave (
        input  en_i, hold_i, scl_i,
        output scl_t, busy_o, fall_tick_o, data_tick_o, samp_tick_o, stretch_o, timeout_o
    );

endinterface

// File: rtl/i2c_sync_2ff.sv
// Two-flop synchroniser for asynchronous pin readback.
// The reset value matches the idle (pulled-up) bus level.
module i2c_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: low/high phase timing, clock-stretch wait with timeout,
// and mid-low / mid-high strobes for the byte/bit engine. All outputs are registered.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int LOW_CYCLES  = LOW_CYCLES_DEF,
    parameter int HIGH_CYCLES = HIGH_CYCLES_DEF,
    parameter int STRETCH_MAX = STRETCH_MAX_DEF
) (
    input logic          clk,
    input logic          rst,
    i2c_scl_gen_if.slave bus
);

    localparam int CNT_W = $clog2(max3(LOW_CYCLES, HIGH_CYCLES, STRETCH_MAX) + 1);

    localparam logic [CNT_W-1:0] LOW_LAST     = CNT_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST    = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DATA_CNT     = CNT_W'(LOW_CYCLES / 2);
    localparam logic [CNT_W-1:0] SAMP_CNT     = CNT_W'(HIGH_CYCLES / 2);
    localparam logic [CNT_W-1:0] STRETCH_LAST = (STRETCH_MAX == 0) ? '0 : CNT_W'(STRETCH_MAX - 1);

    if (LOW_CYCLES < 4 || HIGH_CYCLES < 4) begin : g_param_check
        $error("i2c_scl_gen: LOW_CYCLES and HIGH_CYCLES must both be >= 4");
    end

    scl_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             scl_s;
    logic             timeout_d;

    logic scl_t_q, busy_q, fall_tick_q, data_tick_q, samp_tick_q, stretch_q, timeout_q;
    logic scl_t_d, busy_d, fall_tick_d, data_tick_d, samp_tick_d, stretch_d;

    i2c_sync_2ff #(.RESET_VAL(1'b1)) u_scl_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.scl_i),
        .q_o (scl_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            scl_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            fall_tick_q <= 1'b0;
            data_tick_q <= 1'b0;
            samp_tick_q <= 1'b0;
            stretch_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            scl_t_q     <= scl_t_d;
            busy_q      <= busy_d;
            fall_tick_q <= fall_tick_d;
            data_tick_q <= data_tick_d;
            samp_tick_q <= samp_tick_d;
            stretch_q   <= stretch_d;
            timeout_q   <= timeout_d;
        end
    end

    // Hold at the low terminal count wins over a disable, so SCL is never released early.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.en_i) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (cnt_q == LOW_LAST) begin
                    if (!bus.hold_i) begin
                        state_d = bus.en_i ? WAIT_HI : IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (scl_s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if ((STRETCH_MAX != 0) && (cnt_q == STRETCH_LAST)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q == HIGH_LAST) begin
                    state_d = bus.en_i ? LOW : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    assign scl_t_d     = (state_d != LOW);
    assign busy_d      = (state_d != IDLE);
    assign fall_tick_d = (state_d == LOW) && (state_q != LOW);
    assign data_tick_d = (state_d == LOW) && (cnt_d == DATA_CNT) && (cnt_q != DATA_CNT);
    assign samp_tick_d = (state_d == HIGH) && (cnt_d == SAMP_CNT) && (cnt_q != SAMP_CNT);
    assign stretch_d   = (state_d == WAIT_HI) && !scl_s;

    assign bus.scl_t       = scl_t_q;
    assign bus.busy_o      = busy_q;
    assign bus.fall_tick_o = fall_tick_q;
    assign bus.data_tick_o = data_tick_q;
    assign bus.samp_tick_o = samp_tick_q;
    assign bus.stretch_o   = stretch_q;
    assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen: instance A loops SCL back with an optional slave pull-low,
// instance B (STRETCH_MAX=100) sees SCL stuck low. Outputs are recorded per cycle, then checked.
module tb_i2c_scl_gen;

    localparam int REC_LEN = 2048;
    localparam int B_SCLT  = 6;
    localparam int B_BUSY  = 5;
    localparam int B_FALL  = 4;
    localparam int B_DATA  = 3;
    localparam int B_SAMP  = 2;
    localparam int B_STR   = 1;
    localparam int B_TO    = 0;

    logic clk = 1'b0;
    logic rst;
    logic pullA;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] rec [REC_LEN];

    i2c_scl_gen_if busA ();
    i2c_scl_gen_if busB ();

    assign busA.scl_i = busA.scl_t & ~pullA;
    assign busB.scl_i = 1'b0;

    i2c_scl_gen dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    i2c_scl_gen #(.STRETCH_MAX(100)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic hold, input logic pull);
        busA.en_i   = en;
        busA.hold_i = hold;
        pullA       = pull;
    endtask

    function automatic logic [6:0] packA();
        return {busA.scl_t, busA.busy_o, busA.fall_tick_o, busA.data_tick_o,
                busA.samp_tick_o, busA.stretch_o, busA.timeout_o};
    endfunction

    function automatic logic [6:0] packB();
        return {busB.scl_t, busB.busy_o, busB.fall_tick_o, busB.data_tick_o,
                busB.samp_tick_o, busB.stretch_o, busB.timeout_o};
    endfunction

    function automatic int countOnes(input int b, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i < hi; i++) if (rec[i][b] === 1'b1) n++;
        return n;
    endfunction

    function automatic int runLen(input int b, input logic v, input int start, input int hi);
        int n = 0;
        for (int i = start; i < hi; i++) begin
            if (rec[i][b] !== v) break;
            n++;
        end
        return n;
    endfunction

    function automatic int firstOne(input int b, input int lo, input int hi);
        for (int i = lo; i < hi; i++) if (rec[i][b] === 1'b1) return i;
        return -1;
    endfunction

    initial begin
        rst         = 1'b1;
        busB.en_i   = 1'b0;
        busB.hold_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_scl_t", int'(busA.scl_t), 1);
        checkOutput("rst_busy", int'(busA.busy_o), 0);
        checkOutput("rst_ticks", int'(packA() & 7'h1f), 0);
        checkOutput("rst_b_scl_t", int'(busB.scl_t), 1);
        rst = 1'b0;

        // Disabled: SCL stays released and nothing pulses.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            rec[i] = packA();
        end
        checkOutput("idle_scl_t", countOnes(B_SCLT, 0, 1000), 1000);
        checkOutput("idle_busy", countOnes(B_BUSY, 0, 1000), 0);
        checkOutput("idle_ticks", countOnes(B_FALL, 0, 1000) + countOnes(B_DATA, 0, 1000)
                                  + countOnes(B_SAMP, 0, 1000) + countOnes(B_TO, 0, 1000), 0);

        // Three free-running periods; enable drops at index 1100, inside the third HIGH (1035..1172).
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1250; i++) begin
            @(negedge clk);
            rec[i] = packA();
            if (i == 1100) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("run_first_fall", int'(rec[0][B_FALL]), 1);
        checkOutput("run_low_len", runLen(B_SCLT, 1'b0, 0, 1250), 250);
        checkOutput("run_high_len", runLen(B_SCLT, 1'b1, 250, 1250), 141);
        checkOutput("run_low_len2", runLen(B_SCLT, 1'b0, 391, 1250), 250);
        checkOutput("run_fall2", firstOne(B_FALL, 1, 1250), 391);
        checkOutput("run_fall3", firstOne(B_FALL, 392, 1250), 782);
        checkOutput("run_fall_count", countOnes(B_FALL, 0, 1250), 3);
        checkOutput("run_data_first", firstOne(B_DATA, 0, 1250), 125);
        checkOutput("run_data_second", firstOne(B_DATA, 126, 1250), 516);
        checkOutput("run_data_count", countOnes(B_DATA, 0, 1250), 3);
        checkOutput("run_samp_first", firstOne(B_SAMP, 0, 1250), 322);
        checkOutput("run_samp_count", countOnes(B_SAMP, 0, 1250), 3);
        checkOutput("run_timeout", countOnes(B_TO, 0, 1250), 0);
        checkOutput("stop_busy_last_high", int'(rec[1172][B_BUSY]), 1);
        checkOutput("stop_busy_after", int'(rec[1173][B_BUSY]), 0);
        checkOutput("stop_released", countOnes(B_SCLT, 1035, 1250), 215);

        // Hold 50 cycles at the low terminal count (249), slave pulls SCL low until mid-799,
        // then enable drops during the following LOW (940..1189).
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            rec[i] = packA();
            if (i == 100) applyStimulus(1'b1, 1'b0, 1'b1);
            if (i == 249) applyStimulus(1'b1, 1'b1, 1'b1);
            if (i == 299) applyStimulus(1'b1, 1'b0, 1'b1);
            if (i == 799) applyStimulus(1'b1, 1'b0, 1'b0);
            if (i == 950) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("hold_low_len", runLen(B_SCLT, 1'b0, 0, 1200), 300);
        checkOutput("str_released_len", runLen(B_SCLT, 1'b1, 300, 1200), 640);
        checkOutput("str_mid", int'(rec[400][B_STR]), 1);
        checkOutput("str_len_near_500", int'(countOnes(B_STR, 0, 1200) >= 500
                                             && countOnes(B_STR, 0, 1200) <= 503), 1);
        checkOutput("str_samp", firstOne(B_SAMP, 0, 1200), 871);
        checkOutput("str_no_timeout", countOnes(B_TO, 0, 1200), 0);
        checkOutput("str_next_fall", firstOne(B_FALL, 1, 1200), 940);
        checkOutput("endlow_scl_t", int'(rec[1189][B_SCLT]), 0);
        checkOutput("endlow_release", int'(rec[1190][B_SCLT]), 1);
        checkOutput("endlow_busy", int'(rec[1190][B_BUSY]), 0);
        checkOutput("endlow_fall_count", countOnes(B_FALL, 0, 1200), 2);

        // Synchronous reset at LOW count 100, released one cycle later with enable still set.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rec[i] = packA();
            if (i == 100) rst = 1'b1;
            if (i == 101) rst = 1'b0;
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("mrst_before", int'(rec[100][B_SCLT]), 0);
        checkOutput("mrst_scl_t", int'(rec[101][B_SCLT]), 1);
        checkOutput("mrst_busy", int'(rec[101][B_BUSY]), 0);
        checkOutput("mrst_ticks", int'(rec[101][4:0]), 0);
        checkOutput("mrst_restart_fall", int'(rec[102][B_FALL]), 1);
        checkOutput("mrst_restart_low", runLen(B_SCLT, 1'b0, 102, 400), 250);
        checkOutput("mrst_restart_data", firstOne(B_DATA, 102, 400), 227);

        // Instance B: SCL stuck low, WAIT_HI entered at 250, timeout at count 99 shows at 350.
        busB.en_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rec[i] = packB();
            if (i == 300) busB.en_i = 1'b0;
        end
        checkOutput("to_low_len", runLen(B_SCLT, 1'b0, 0, 400), 250);
        checkOutput("to_stretch", int'(rec[300][B_STR]), 1);
        checkOutput("to_pulse_at", firstOne(B_TO, 0, 400), 350);
        checkOutput("to_pulse_count", countOnes(B_TO, 0, 400), 1);
        checkOutput("to_busy_before", int'(rec[349][B_BUSY]), 1);
        checkOutput("to_busy_after", int'(rec[350][B_BUSY]), 0);
        checkOutput("to_scl_t_after", int'(rec[350][B_SCLT]), 1);
        checkOutput("to_stays_idle", countOnes(B_BUSY, 351, 400), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
